// File: rtl/icu.sv
// MC14500B-style single-bit industrial control unit: one 4-bit instruction per clock
// operating on a 1-bit result register, with input/output enable gating.

package instructions;
  typedef enum logic [3:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;
endpackage

module icu (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_in,
  input  instructions::instruction_t i,
  output logic                      write,
  output logic                      data_out,
  output logic                      jmp,
  output logic                      rtn,
  output logic                      flag_o,
  output logic                      flag_f,
  output logic                      rr_out
);
  import instructions::*;

  logic r_rr;
  logic r_skip;
  logic r_write;
  logic r_data_out;
  logic r_jmp;
  logic r_rtn;
  logic r_flag_o;
  logic r_flag_f;
  logic ien_register;
  logic oen_register;
  logic w_data;

  assign w_data = data_in & ien_register;

  // Pulses default low every cycle; a pending skip swallows exactly one instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr         <= 1'b0;
      r_skip       <= 1'b0;
      r_write      <= 1'b0;
      r_data_out   <= 1'b0;
      r_jmp        <= 1'b0;
      r_rtn        <= 1'b0;
      r_flag_o     <= 1'b0;
      r_flag_f     <= 1'b0;
      ien_register <= 1'b0;
      oen_register <= 1'b0;
    end else begin
      r_write  <= 1'b0;
      r_jmp    <= 1'b0;
      r_rtn    <= 1'b0;
      r_flag_o <= 1'b0;
      r_flag_f <= 1'b0;
      r_skip   <= 1'b0;
      if (!r_skip) begin
        case (i)
          NOPO: r_flag_o <= 1'b1;
          LD:   r_rr <= w_data;
          LDC:  r_rr <= ~w_data;
          AND:  r_rr <= r_rr & w_data;
          ANDC: r_rr <= r_rr & ~w_data;
          OR:   r_rr <= r_rr | w_data;
          ORC:  r_rr <= r_rr | ~w_data;
          XNOR: r_rr <= ~(r_rr ^ w_data);
          STO: begin
            if (oen_register) begin
              r_write    <= 1'b1;
              r_data_out <= r_rr;
            end
          end
          STOC: begin
            if (oen_register) begin
              r_write    <= 1'b1;
              r_data_out <= ~r_rr;
            end
          end
          IEN:  ien_register <= data_in;
          OEN:  oen_register <= data_in;
          JMP:  r_jmp <= 1'b1;
          RTN: begin
            r_rtn  <= 1'b1;
            r_skip <= 1'b1;
          end
          SKZ:  r_skip <= ~r_rr;
          NOPF: r_flag_f <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign write    = r_write;
  assign data_out = r_data_out;
  assign jmp      = r_jmp;
  assign rtn      = r_rtn;
  assign flag_o   = r_flag_o;
  assign flag_f   = r_flag_f;
  assign rr_out   = r_rr;

endmodule

// File: tb/tb_icu.sv
// Scoreboard bench for icu: directed instructions push hand-computed expectations,
// a negedge monitor pops and compares outputs plus the enable latches.
`timescale 1ns/1ps

module tb_icu;
  import instructions::*;

  logic         clk;
  logic         rst;
  logic         data_in;
  instruction_t i;
  logic         write;
  logic         data_out;
  logic         jmp;
  logic         rtn;
  logic         flag_o;
  logic         flag_f;
  logic         rr_out;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sbQ[$];
  int checks;
  int failures;

  icu dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .i        (i),
    .write    (write),
    .data_out (data_out),
    .jmp      (jmp),
    .rtn      (rtn),
    .flag_o   (flag_o),
    .flag_f   (flag_f),
    .rr_out   (rr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector bit order: rr write data_out jmp rtn flag_o flag_f ien oen
  task automatic applyStimulus(input instruction_t op, input logic d, input logic r,
                               input logic [8:0] e, input string n);
    sb_entry_t ent;
    @(negedge clk);
    i       = op;
    data_in = d;
    rst     = r;
    @(posedge clk);
    #1;
    ent.exp  = e;
    ent.name = n;
    sbQ.push_back(ent);
  endtask

  task automatic checkOutput(input sb_entry_t ent);
    logic [8:0] act;
    act = {rr_out, write, data_out, jmp, rtn, flag_o, flag_f,
           dut.ien_register, dut.oen_register};
    checks++;
    if (act !== ent.exp) begin
      failures++;
      $display("[TB] FAIL %s: got rr,wr,do,jmp,rtn,fo,ff,ien,oen=%b expected %b",
               ent.name, act, ent.exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    data_in  = 1'b0;
    i        = NOPO;

    applyStimulus(LD,   1'b1, 1'b0, 9'b000000000, "reset_edge1");
    applyStimulus(NOPO, 1'b1, 1'b0, 9'b000000000, "reset_edge2");
    applyStimulus(JMP,  1'b1, 1'b0, 9'b000000000, "reset_edge3");

    applyStimulus(IEN,  1'b0, 1'b1, 9'b000000000, "ien_0");
    applyStimulus(IEN,  1'b1, 1'b1, 9'b000000010, "ien_1");
    applyStimulus(OEN,  1'b0, 1'b1, 9'b000000010, "oen_0");
    applyStimulus(OEN,  1'b1, 1'b1, 9'b000000011, "oen_1");

    applyStimulus(LD,   1'b1, 1'b1, 9'b100000011, "ld_1");
    applyStimulus(LDC,  1'b0, 1'b1, 9'b100000011, "ldc_0");
    applyStimulus(OR,   1'b0, 1'b1, 9'b100000011, "or_0");
    applyStimulus(OR,   1'b1, 1'b1, 9'b100000011, "or_1");
    applyStimulus(STO,  1'b0, 1'b1, 9'b111000011, "sto_rr1");
    applyStimulus(AND,  1'b1, 1'b1, 9'b101000011, "and_1");
    applyStimulus(AND,  1'b0, 1'b1, 9'b001000011, "and_0");
    applyStimulus(STO,  1'b0, 1'b1, 9'b010000011, "sto_rr0");

    applyStimulus(NOPO, 1'b0, 1'b1, 9'b000001011, "nopo");
    applyStimulus(NOPF, 1'b0, 1'b1, 9'b000000111, "nopf");
    applyStimulus(LD,   1'b1, 1'b1, 9'b100000011, "ld_after_flags");

    applyStimulus(ANDC, 1'b1, 1'b1, 9'b000000011, "andc_1");
    applyStimulus(ORC,  1'b1, 1'b1, 9'b000000011, "orc_1");
    applyStimulus(ORC,  1'b0, 1'b1, 9'b100000011, "orc_0");
    applyStimulus(XNOR, 1'b1, 1'b1, 9'b100000011, "xnor_1");
    applyStimulus(XNOR, 1'b0, 1'b1, 9'b000000011, "xnor_0");
    applyStimulus(STOC, 1'b0, 1'b1, 9'b011000011, "stoc_rr0");

    applyStimulus(IEN,  1'b0, 1'b1, 9'b001000001, "gate_ien_off");
    applyStimulus(LD,   1'b1, 1'b1, 9'b001000001, "gated_ld_1");
    applyStimulus(LDC,  1'b1, 1'b1, 9'b101000001, "gated_ldc_1");
    applyStimulus(OEN,  1'b0, 1'b1, 9'b101000000, "gate_oen_off");
    applyStimulus(STOC, 1'b0, 1'b1, 9'b101000000, "gated_stoc");
    applyStimulus(IEN,  1'b1, 1'b1, 9'b101000010, "ien_restore");
    applyStimulus(OEN,  1'b1, 1'b1, 9'b101000011, "oen_restore");

    applyStimulus(LD,   1'b0, 1'b1, 9'b001000011, "ld_0");
    applyStimulus(SKZ,  1'b0, 1'b1, 9'b001000011, "skz_rr0");
    applyStimulus(LD,   1'b1, 1'b1, 9'b001000011, "skipped_ld");
    applyStimulus(LD,   1'b1, 1'b1, 9'b101000011, "ld_after_skip");
    applyStimulus(SKZ,  1'b0, 1'b1, 9'b101000011, "skz_rr1");
    applyStimulus(LD,   1'b0, 1'b1, 9'b001000011, "ld_not_skipped");

    applyStimulus(RTN,  1'b0, 1'b1, 9'b001010011, "rtn");
    applyStimulus(LD,   1'b1, 1'b1, 9'b001000011, "skipped_after_rtn");
    applyStimulus(LD,   1'b1, 1'b1, 9'b101000011, "ld_after_rtn_skip");
    applyStimulus(LD,   1'b0, 1'b1, 9'b001000011, "ld_0_again");
    applyStimulus(RTN,  1'b0, 1'b1, 9'b001010011, "rtn_rr0");
    applyStimulus(SKZ,  1'b0, 1'b1, 9'b001000011, "skipped_skz");
    applyStimulus(LD,   1'b1, 1'b1, 9'b101000011, "no_rearm_ld");
    applyStimulus(RTN,  1'b0, 1'b1, 9'b101010011, "rtn_rr1");
    applyStimulus(STOC, 1'b0, 1'b1, 9'b101000011, "skipped_stoc");

    applyStimulus(JMP,  1'b0, 1'b1, 9'b101100011, "jmp");
    applyStimulus(NOPO, 1'b0, 1'b1, 9'b101001011, "nopo_after_jmp");

    applyStimulus(STO,  1'b1, 1'b0, 9'b000000000, "midrun_reset");
    applyStimulus(NOPF, 1'b0, 1'b1, 9'b000000100, "after_reset_nopf");

    for (int k = 0; k < 5 && sbQ.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sbQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icu.md
Name: icu

Overview:
- Single-bit industrial control unit (MC14500B-style) executing one 4-bit instruction per clock on a 1-bit result register (RR).
- Gates input data with an input-enable latch (IEN) and output writes with an output-enable latch (OEN).
- Emits jump/return/flag pulses for the external program counter and sequencer.
- Sits between the program ROM/sequencer and the 1-bit I/O bus.

Parameters:
- None. Opcode encoding is fixed by the shared `instructions` package type `instruction_t` (4 bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- data_in  input  1  data bus read value
- i  input  4 (instruction_t)  instruction for this cycle
- write  output  1  store strobe
- data_out  output  1  data bus write value
- jmp  output  1  JMP pulse
- rtn  output  1  RTN pulse
- flag_o  output  1  NOPO pulse
- flag_f  output  1  NOPF pulse
- rr_out  output  1  current RR value

Behaviour:
- All state updates on the rising edge of clk; all outputs registered.
- Outputs reflect the instruction sampled at the most recent edge, one cycle latency.
- Reset (rst==0 at an edge) has priority over everything:
  - clears RR, ien_register, oen_register and the skip flag;
  - drives write, data_out, jmp, rtn, flag_o, flag_f and rr_out to 0.
- Internal registers must be named `ien_register` and `oen_register`; the bench reads them hierarchically.
- Effective data D = data_in & ien_register.
- Opcodes:
  - 0 NOPO: flag_o=1.
  - 1 LD: RR=D.
  - 2 LDC: RR=~D.
  - 3 AND: RR=RR&D.
  - 4 ANDC: RR=RR&~D.
  - 5 OR: RR=RR|D.
  - 6 ORC: RR=RR|~D.
  - 7 XNOR: RR=~(RR^D).
  - 8 STO: if oen_register, write=1 and data_out=RR.
  - 9 STOC: if oen_register, write=1 and data_out=~RR.
  - A IEN: ien_register=data_in (raw).
  - B OEN: oen_register=data_in (raw).
  - C JMP: jmp=1.
  - D RTN: rtn=1, skip=1.
  - E SKZ: skip=1 if RR==0.
  - F NOPF: flag_f=1.
- Pulse outputs (write, jmp, rtn, flag_o, flag_f) are high for exactly one cycle after their instruction, otherwise 0.
- data_out holds its last stored value until the next enabled STO/STOC or reset.
- STO/STOC with oen_register==0: write stays 0, data_out unchanged.
- STO/STOC use the RR value from before the edge.
- Skip: when skip==1, the next instruction is ignored:
  - no register change, no pulses;
  - skip clears on that edge;
  - a skipped SKZ/RTN does not re-arm skip.
- rr_out always equals RR.

Test Plan:
- Reset: hold rst=0 for 3 edges, release -> rr_out, data_out, write, flags all 0; ien_register=0, oen_register=0.
- Enables: IEN with data_in=0 -> ien_register=0; IEN with 1 -> 1; OEN with 0 -> oen_register=0; OEN with 1 -> 1.
- Logic ops with IEN=1:
  - LD 1 -> rr_out=1; LDC 0 -> 1; OR 0 -> 1; OR 1 -> 1;
  - STO -> data_out=1, write=1 for one cycle;
  - AND 1 -> 1; AND 0 -> 0; STO -> data_out=0.
- Flags: NOPO -> flag_o=1, flag_f=0; next NOPF -> flag_o=0, flag_f=1; next LD -> both 0.
- Gating:
  - IEN=0, then LD data_in=1 -> rr_out=0;
  - OEN=0, then STO -> write=0, data_out unchanged.
- Skip:
  - RR=0, SKZ, LD 1 (IEN=1) -> rr_out stays 0; following LD 1 -> rr_out=1.
  - RTN -> rtn=1 one cycle, next instruction skipped.
  - JMP -> jmp=1 one cycle.
